fruit_scheduler: RTL
====================

Name: fruit_scheduler

Overview:
- Owns the vertical motion of NUM_FRUITS hanging fruits and sequences each one through hang, fall and respawn.
- Uses one shared fixed-point update datapath, time-multiplexed across slots: one slot per clk after each startOfFrame.
- Sits between the collision logic (hit/kill pulses in) and the fruit drawers (per-slot Y, visible and falling flags out).

Parameters:
- NUM_FRUITS, 4, number of fruit slots (1..16)
- INITIAL_Y, 226, spawn Y in pixels
- MIN_Y, 200, upper bound of the hang oscillation, pixels
- MAX_Y, 260, lower bound of the hang oscillation, pixels
- HANG_SPEED, 40, hang speed in 1/128 pixel per frame
- GRAVITY, 8, fall acceleration in 1/128 pixel per frame²
- MAX_FALL_SPEED, 512, fall speed cap in 1/128 pixel per frame
- FLOOR_Y, 544, Y at which a falling fruit disappears
- RESPAWN_FRAMES, 90, frames spent hidden before respawn

Ports:
- clk  in  1  clock
- resetN  in  1  asynchronous, active-low reset
- startOfFrame  in  1  one-clk pulse per frame
- hitReq  in  NUM_FRUITS  one-clk pulse: player touched fruit k
- enemyHit  in  NUM_FRUITS  one-clk pulse: fruit k touched an enemy
- topLeftY  out  NUM_FRUITS x 11 signed  per-slot Y in pixels
- visible  out  NUM_FRUITS  slot drawn
- falling  out  NUM_FRUITS  slot is in FALL state
- scorePulse  out  1  one-clk pulse when an enemy is killed
- busy  out  1  scheduler is updating slots
- overrun  out  1  sticky: startOfFrame arrived while busy

Behaviour:
- Fixed point: Y and speed are signed 32-bit, 7 fractional bits. topLeftY = Y >>> 7 (arithmetic shift, floor).
- Reset state of every slot:
  - state HANG, Y = INITIAL_Y·128, speed = +HANG_SPEED, respawn timer 0.
  - Outputs: visible all 1, falling 0, scorePulse 0, busy 0, overrun 0, topLeftY = INITIAL_Y.
- Scheduler FSM:
  - SCHED_IDLE: startOfFrame → SCHED_RUN with idx = 0, busy = 1.
  - SCHED_RUN: each clk, slot idx is serviced (read, compute, write back) and idx increments. After slot NUM_FRUITS-1 → SCHED_IDLE.
  - A full pass takes exactly NUM_FRUITS clks.
  - startOfFrame while busy is ignored and sets overrun. overrun clears only on reset.
- Pending events:
  - hitPending[k] and killPending[k] are set by the input pulses.
  - Both are cleared when slot k is serviced.
  - A pulse arriving in the same clk slot k is serviced is consumed by that service (OR'd in).
  - Pending bits for the slot not being serviced are retained.
- Slot FSM (evaluated at service):
  - HANG:
    - hit pending → FALL, speed = 0, Y unchanged.
    - Otherwise bounce: if Y <= MIN_Y·128 and speed < 0, speed = -speed; if Y >= MAX_Y·128 and speed > 0, speed = -speed.
    - Then Y += speed, using the new speed.
    - killPending is ignored in HANG.
  - FALL:
    - kill pending → IDLE, timer = RESPAWN_FRAMES, scorePulse asserted the following clk.
    - Otherwise speed = min(speed + GRAVITY, MAX_FALL_SPEED), then Y += new speed.
    - If the new Y >= FLOOR_Y·128 → IDLE, timer = RESPAWN_FRAMES (no score).
    - hitPending is ignored in FALL.
  - IDLE:
    - All pending events are discarded.
    - If timer == 0 → HANG, Y = INITIAL_Y·128, speed = +HANG_SPEED; otherwise timer -= 1.
    - The timer never wraps.
- Output timing:
  - visible = (state != IDLE); falling = (state == FALL).
  - All outputs are registered and reflect the service one clk after it.
  - scorePulse pulses for one clk per kill. Kills in successive service clks give successive pulses.
- Async reset mid-pass: the pass is abandoned and all state returns to reset values.

Optional Feature:
- Macro: FRUIT_RANDOM_RESPAWN_EN.
- Defined: a 16-bit Galois LFSR (taps 16,14,13,11, seed 16'hACE1 at reset) steps every startOfFrame. The respawn timer loads RESPAWN_FRAMES + lfsr[5:0].
- Undefined: the timer loads exactly RESPAWN_FRAMES and no LFSR exists.

Decomposition:
- Shared package fruit_pkg:
  - slot_state_t enum {IDLE, HANG, FALL}
  - sched_state_t enum {SCHED_IDLE, SCHED_RUN}
  - FIXED_POINT_SHIFT = 7
  - slot_rec_t struct {state, Y, speed, timer}
- Sub-module fruit_slot_calc: combinational next slot_rec_t plus score flag from the current record and the pending bits. It is instantiated once, as the shared datapath.

Test Plan:
- Reset, NUM_FRUITS=4, then one startOfFrame → busy high for exactly 4 clks; every topLeftY = 226 after reset; slot0 Y fixed-point goes 28928 → 28968.
- Hang, 100 frames, no hits → each topLeftY stays within 199..261; speed sign flips at MIN_Y/MAX_Y crossings; Y never steps by more than 40/128 px per frame.
- hitReq[2] pulse, then frames → falling[2] = 1; speed sequence 8, 16, 24, …, capped at 512; reaching Y ≥ 544 → visible[2] = 0, scorePulse never asserted.
- hitReq[1], then enemyHit[1] during FALL → exactly one scorePulse; visible[1] = 0; after 90 more frames (+1 service) visible[1] = 1 and topLeftY[1] = 226.
- hitReq[0] asserted in the clk slot 0 is serviced → consumed that frame, no duplicate effect next frame. enemyHit during HANG → ignored, no score.
- startOfFrame pulsed twice 2 clks apart → second pulse ignored, overrun = 1 and stays set until resetN.

Source files
------------

// File: rtl/fruit_pkg.sv
// Shared types and constants for the fruit scheduler and its slot datapath.
package fruit_pkg;

  localparam int unsigned FIXED_POINT_SHIFT = 7;
  localparam int unsigned TIMER_W           = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HANG = 2'd1,
    FALL = 2'd2
  } slot_state_t;

  typedef enum logic {
    SCHED_IDLE = 1'b0,
    SCHED_RUN  = 1'b1
  } sched_state_t;

  typedef struct packed {
    slot_state_t         state;
    logic signed [31:0]  y;
    logic signed [31:0]  speed;
    logic [TIMER_W-1:0]  timer;
  } slot_rec_t;

  function automatic logic signed [10:0] to_pixels(input logic signed [31:0] fx);
    logic signed [31:0] px;
    px = fx >>> FIXED_POINT_SHIFT;
    return px[10:0];
  endfunction

endpackage

// File: rtl/fruit_slot_calc.sv
// Combinational next-record logic for one fruit slot; the scheduler shares a single
// instance across all slots.
module fruit_slot_calc
  import fruit_pkg::*;
#(
  parameter int INITIAL_Y      = 226,
  parameter int MIN_Y          = 200,
  parameter int MAX_Y          = 260,
  parameter int HANG_SPEED     = 40,
  parameter int GRAVITY        = 8,
  parameter int MAX_FALL_SPEED = 512,
  parameter int FLOOR_Y        = 544
) (
  input  slot_rec_t          cur,
  input  logic               hit,
  input  logic               kill,
  input  logic [TIMER_W-1:0] respawn_load,
  output slot_rec_t          nxt,
  output logic               score
);

  localparam logic signed [31:0] InitYFx   = 32'(INITIAL_Y * (2 ** FIXED_POINT_SHIFT));
  localparam logic signed [31:0] MinYFx    = 32'(MIN_Y * (2 ** FIXED_POINT_SHIFT));
  localparam logic signed [31:0] MaxYFx    = 32'(MAX_Y * (2 ** FIXED_POINT_SHIFT));
  localparam logic signed [31:0] FloorYFx  = 32'(FLOOR_Y * (2 ** FIXED_POINT_SHIFT));
  localparam logic signed [31:0] HangSpd   = 32'(HANG_SPEED);
  localparam logic signed [31:0] Grav      = 32'(GRAVITY);
  localparam logic signed [31:0] MaxFall   = 32'(MAX_FALL_SPEED);

  logic signed [31:0] spd;
  logic signed [31:0] ypos;

  always_comb begin
    nxt   = cur;
    score = 1'b0;
    spd   = cur.speed;
    ypos  = cur.y;
    unique case (cur.state)
      HANG: begin
        if (hit) begin
          nxt.state = FALL;
          nxt.speed = '0;
        end else begin
          if (ypos <= MinYFx && spd < 0) begin
            spd = -spd;
          end else if (ypos >= MaxYFx && spd > 0) begin
            spd = -spd;
          end
          nxt.speed = spd;
          nxt.y     = ypos + spd;
        end
      end
      FALL: begin
        if (kill) begin
          nxt.state = IDLE;
          nxt.timer = respawn_load;
          score     = 1'b1;
        end else begin
          spd = spd + Grav;
          if (spd > MaxFall) spd = MaxFall;
          ypos      = ypos + spd;
          nxt.speed = spd;
          nxt.y     = ypos;
          if (ypos >= FloorYFx) begin
            nxt.state = IDLE;
            nxt.timer = respawn_load;
          end
        end
      end
      IDLE: begin
        if (cur.timer == '0) begin
          nxt.state = HANG;
          nxt.y     = InitYFx;
          nxt.speed = HangSpd;
        end else begin
          nxt.timer = cur.timer - TIMER_W'(1);
        end
      end
      default: nxt.state = IDLE;
    endcase
  end

endmodule

// File: rtl/fruit_scheduler.sv
// Time-multiplexed fruit motion scheduler: services one slot per clk after startOfFrame.
// Optional macro FRUIT_RANDOM_RESPAWN_EN adds an LFSR jitter to the respawn delay.
module fruit_scheduler
  import fruit_pkg::*;
#(
  parameter int unsigned NUM_FRUITS     = 4,
  parameter int          INITIAL_Y      = 226,
  parameter int          MIN_Y          = 200,
  parameter int          MAX_Y          = 260,
  parameter int          HANG_SPEED     = 40,
  parameter int          GRAVITY        = 8,
  parameter int          MAX_FALL_SPEED = 512,
  parameter int          FLOOR_Y        = 544,
  parameter int          RESPAWN_FRAMES = 90
) (
  input  logic                  clk,
  input  logic                  resetN,
  input  logic                  startOfFrame,
  input  logic [NUM_FRUITS-1:0] hitReq,
  input  logic [NUM_FRUITS-1:0] enemyHit,
  output logic signed [10:0]    topLeftY [NUM_FRUITS],
  output logic [NUM_FRUITS-1:0] visible,
  output logic [NUM_FRUITS-1:0] falling,
  output logic                  scorePulse,
  output logic                  busy,
  output logic                  overrun
);

  localparam int unsigned IdxW = (NUM_FRUITS > 1) ? $clog2(NUM_FRUITS) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NUM_FRUITS - 1);
  localparam logic signed [31:0] InitYFx = 32'(INITIAL_Y * (2 ** FIXED_POINT_SHIFT));

  sched_state_t          sched_q, sched_d;
  logic [IdxW-1:0]       idx_q, idx_d;
  logic                  service;
  slot_rec_t             recs_q [NUM_FRUITS];
  slot_rec_t             cur_rec, nxt_rec;
  logic                  calc_score;
  logic                  svc_hit, svc_kill;
  logic [NUM_FRUITS-1:0] hit_pend_q, hit_pend_d;
  logic [NUM_FRUITS-1:0] kill_pend_q, kill_pend_d;
  logic                  score_q;
  logic                  overrun_q;
  logic [TIMER_W-1:0]    respawn_load;

  // Scheduler FSM: state register
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      sched_q <= SCHED_IDLE;
      idx_q   <= '0;
    end else begin
      sched_q <= sched_d;
      idx_q   <= idx_d;
    end
  end

  // Scheduler FSM: next state
  always_comb begin
    sched_d = sched_q;
    idx_d   = idx_q;
    unique case (sched_q)
      SCHED_IDLE: begin
        if (startOfFrame) begin
          sched_d = SCHED_RUN;
          idx_d   = '0;
        end
      end
      SCHED_RUN: begin
        if (idx_q == LastIdx) begin
          sched_d = SCHED_IDLE;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + IdxW'(1);
        end
      end
      default: sched_d = SCHED_IDLE;
    endcase
  end

  // Scheduler FSM: outputs
  always_comb begin
    busy    = (sched_q == SCHED_RUN);
    service = busy;
  end

  // A pulse landing in the same clk as its slot's service is folded into that service.
  always_comb begin
    hit_pend_d  = hit_pend_q | hitReq;
    kill_pend_d = kill_pend_q | enemyHit;
    svc_hit     = hit_pend_q[idx_q] | hitReq[idx_q];
    svc_kill    = kill_pend_q[idx_q] | enemyHit[idx_q];
    if (service) begin
      hit_pend_d[idx_q]  = 1'b0;
      kill_pend_d[idx_q] = 1'b0;
    end
  end

  assign cur_rec = recs_q[idx_q];

  fruit_slot_calc #(
    .INITIAL_Y      (INITIAL_Y),
    .MIN_Y          (MIN_Y),
    .MAX_Y          (MAX_Y),
    .HANG_SPEED     (HANG_SPEED),
    .GRAVITY        (GRAVITY),
    .MAX_FALL_SPEED (MAX_FALL_SPEED),
    .FLOOR_Y        (FLOOR_Y)
  ) u_calc (
    .cur          (cur_rec),
    .hit          (svc_hit),
    .kill         (svc_kill),
    .respawn_load (respawn_load),
    .nxt          (nxt_rec),
    .score        (calc_score)
  );

`ifdef FRUIT_RANDOM_RESPAWN_EN
  logic [15:0] lfsr_q;

  // Galois form, taps 16,14,13,11
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      lfsr_q <= 16'hACE1;
    end else if (startOfFrame) begin
      lfsr_q <= {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
    end
  end

  assign respawn_load = TIMER_W'(RESPAWN_FRAMES) + TIMER_W'(lfsr_q[5:0]);
`else
  assign respawn_load = TIMER_W'(RESPAWN_FRAMES);
`endif

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      for (int i = 0; i < int'(NUM_FRUITS); i++) begin
        recs_q[i].state <= HANG;
        recs_q[i].y     <= InitYFx;
        recs_q[i].speed <= 32'(HANG_SPEED);
        recs_q[i].timer <= '0;
      end
    end else if (service) begin
      recs_q[idx_q] <= nxt_rec;
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      hit_pend_q  <= '0;
      kill_pend_q <= '0;
      score_q     <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      hit_pend_q  <= hit_pend_d;
      kill_pend_q <= kill_pend_d;
      score_q     <= service & calc_score;
      if (startOfFrame && busy) overrun_q <= 1'b1;
    end
  end

  always_comb begin
    for (int i = 0; i < int'(NUM_FRUITS); i++) begin
      topLeftY[i] = to_pixels(recs_q[i].y);
      visible[i]  = (recs_q[i].state != IDLE);
      falling[i]  = (recs_q[i].state == FALL);
    end
    scorePulse = score_q;
    overrun    = overrun_q;
  end

endmodule
